// File: rtl/pixel_readout_bus.sv
// Gray-coded pixel row capture into a tagged FWFT FIFO; out_parity exists only with PIXEL_READOUT_PARITY_EN.
// Capture-to-out_valid 1 cycle; downstream stalls via out_ready, captures into a full FIFO are dropped and flagged.

module pixel_readout_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_vld,
   input  logic [W-1:0]     wr_dat,
   input  logic             rd_rdy,
   output logic             rd_vld,
   output logic [W-1:0]     rd_dat,
   output logic [LVL_W-1:0] level,
   output logic             wr_drop
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (level == LVL_W'(DEPTH));
   assign rd_vld  = (level != '0);
   assign rd_fire = rd_vld & rd_rdy;
   // a full FIFO still takes a word when the head leaves on the same edge
   assign wr_fire = wr_vld & (~full | rd_fire);
   assign wr_drop = wr_vld & full & ~rd_fire;
   assign rd_dat  = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_fire, rd_fire})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

module pixel_readout_bus #(
   parameter int NUM_ROWS    = 2,
   parameter int PIX_PER_ROW = 2,
   parameter int BIT_W       = 8,
   parameter int FIFO_DEPTH  = 4,
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
   localparam int PW    = PIX_PER_ROW * BIT_W
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_ROWS-1:0]             read,
   input  logic [NUM_ROWS*PW-1:0]          pixData,
   output logic [PW-1:0]                   pixelDataOut,
   output logic [ROW_W-1:0]                out_row,
   output logic                            out_valid,
   input  logic                            out_ready,
   input  logic                            clear_flags,
   output logic                            overflow,
   output logic                            collision,
`ifdef PIXEL_READOUT_PARITY_EN
   output logic                            out_parity,
`endif
   output logic [LVL_W-1:0]                level
);

`ifdef PIXEL_READOUT_PARITY_EN
   localparam int EW = PW + ROW_W + 1;
`else
   localparam int EW = PW + ROW_W;
`endif

   logic [ROW_W-1:0] sel_row;
   logic [PW-1:0]    row_gray;
   logic [PW-1:0]    row_bin;
   logic [BIT_W-1:0] pix_g;
   logic [BIT_W-1:0] pix_b;
   logic             col_evt;
   logic             ovf_evt;
   logic [EW-1:0]    wr_dat;
   logic [EW-1:0]    rd_dat;

   // lowest-index asserted row wins
   always_comb begin
      sel_row = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (read[r]) begin
            sel_row = ROW_W'(r);
         end
      end
   end

   always_comb begin
      row_gray = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (sel_row == ROW_W'(r)) begin
            row_gray = pixData[r*PW +: PW];
         end
      end
   end

   // pixel 0 lands in the MSBs of the output word
   always_comb begin
      row_bin = '0;
      pix_g   = '0;
      pix_b   = '0;
      for (int p = 0; p < PIX_PER_ROW; p++) begin
         pix_g = row_gray[p*BIT_W +: BIT_W];
         pix_b[BIT_W-1] = pix_g[BIT_W-1];
         for (int i = BIT_W - 2; i >= 0; i--) begin
            pix_b[i] = pix_b[i+1] ^ pix_g[i];
         end
         row_bin[(PIX_PER_ROW-1-p)*BIT_W +: BIT_W] = pix_b;
      end
   end

   assign col_evt = |(read & (read - NUM_ROWS'(1)));

`ifdef PIXEL_READOUT_PARITY_EN
   assign wr_dat = {^row_bin, sel_row, row_bin};
   assign {out_parity, out_row, pixelDataOut} = rd_dat;
`else
   assign wr_dat = {sel_row, row_bin};
   assign {out_row, pixelDataOut} = rd_dat;
`endif

   pixel_readout_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_vld  (|read),
      .wr_dat  (wr_dat),
      .rd_rdy  (out_ready),
      .rd_vld  (out_valid),
      .rd_dat  (rd_dat),
      .level   (level),
      .wr_drop (ovf_evt)
   );

   // a new event on the clearing edge keeps its flag set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         collision <= 1'b0;
      end else begin
         overflow  <= ovf_evt | (overflow & ~clear_flags);
         collision <= col_evt | (collision & ~clear_flags);
      end
   end

endmodule
